board_renderer: RTL
===================

BOARD_RENDERER -- requirements
Module: board_renderer

Interface
REQ-001 Parameter CELL_SIZE, default 96: edge length in pixels of one board cell.
REQ-002 Parameter BOARD_X0, default 128: x pixel of the board's left edge.
REQ-003 Parameter BOARD_Y0, default 0: y pixel of the board's top edge.
REQ-004 Parameter BLINK_FRAMES, default 30: number of frames per cursor blink phase.
REQ-005 i_clk  in  1: single clock, shared with the VGA timing stage; all logic is synchronous to its rising edge.
REQ-006 i_rst  in  1: synchronous, active-high reset.
REQ-007 i_wr_en  in  1: write strobe to the working board.
REQ-008 i_wr_addr  in  5: cell index, row-major, 0..19 (4 columns x 5 rows).
REQ-009 i_wr_data  in  4: block id; 0 = empty, 1..10 = piece.
REQ-010 i_cursor  in  5: selected cell index.
REQ-011 i_frame_start  in  1: one-cycle pulse from the VGA stage at the start of vertical blank.
REQ-012 i_px_valid  in  1: pixel request valid.
REQ-013 i_px_x, i_px_y  in  10 each: requested pixel coordinate.
REQ-014 o_px_valid  out  1: response valid.
REQ-015 o_r, o_g, o_b  out  8 each: pixel colour, feeding VGA_R/G/B.

Function
REQ-016 The working board SHALL be 20 x 4-bit registers; a write with i_wr_en=1 and i_wr_addr>=20 SHALL be ignored.
REQ-017 On i_frame_start, the display board SHALL copy the working board and the display cursor SHALL copy i_cursor; rendering SHALL read only display copies (no tearing).
REQ-018 When a write and i_frame_start occur in the same cycle, the display copy SHALL take the pre-write value; the write SHALL land in the working board only.
REQ-019 Blink counter: increments on each i_frame_start; on reaching BLINK_FRAMES-1 it wraps to 0 and the blink phase toggles.
REQ-020 Pipeline latency SHALL be exactly 2 cycles: o_px_valid(t+2) = i_px_valid(t); one request per cycle is accepted with no stall.
REQ-021 Stage 1 SHALL register: inside flag (BOARD_X0<=x<BOARD_X0+4*CELL_SIZE and BOARD_Y0<=y<BOARD_Y0+5*CELL_SIZE), column 0..3, row 0..4, and in-cell offsets ox, oy in 0..CELL_SIZE-1, using compare chains with no divider.
REQ-022 Stage 2 SHALL look up the cell id and its four neighbours and register the colour.
REQ-023 Outside the board, the colour SHALL be 000000.
REQ-024 Border: a pixel with ox<2, ox>=CELL_SIZE-2, oy<2 or oy>=CELL_SIZE-2 SHALL be 000000 when the neighbour across that edge has a different id or lies off-board, so outlines are drawn at piece boundaries only.
REQ-025 Palette (RGB hex): id0 404040; id1 E02020; id2-5 2060E0; id6-9 20C040; id10 E0C020; ids 11-15 are rendered as id0.
REQ-026 In the display-cursor cell, a non-border pixel SHALL be the bitwise inverse of its palette colour when the blink phase is 1.
REQ-027 When o_px_valid=0, o_r/o_g/o_b SHALL be 0.

Reset
REQ-028 On i_rst=1, the working board, display board, display cursor, blink counter, blink phase, pipeline valids and outputs SHALL all be 0.
REQ-029 On i_rst=1, in-flight pixels SHALL be discarded; o_px_valid SHALL be 0 during reset and 0 for the first 2 cycles after deassertion.

Verification
REQ-030 After reset, request (128,0) valid -> two cycles later o_px_valid=1 and colour 000000 (off-board border); request (200,50) -> 404040.
REQ-031 Write addr0=1, addr1=1, addr4=1, addr5=1, then pulse i_frame_start; request (224,50) -> E02020 (interior seam, no border); request (129,50) -> 000000.
REQ-032 Write addr2=2 without i_frame_start; request (350,50) -> 404040; after i_frame_start -> 2060E0.
REQ-033 Same-cycle write addr3=6 and i_frame_start; request (450,50) -> 404040; after the next i_frame_start -> 20C040.
REQ-034 Set i_cursor=0, cell0 id1, issue 30 frame_starts; request (150,50) -> 1FDFDF; after 30 more frame_starts -> E02020.
REQ-035 Stream requests on 5 consecutive cycles, assert i_rst on the 3rd -> no o_px_valid pulse for any request issued at or before reset; invalid write addr 25 leaves all cells 0.

Source files
------------

// File: rtl/board_renderer_if.sv
// Pixel request/response and board-update signals between the game logic,
// the VGA timing stage and the board renderer.
interface board_renderer_if;
    logic       i_wr_en;
    logic [4:0] i_wr_addr;
    logic [3:0] i_wr_data;
    logic [4:0] i_cursor;
    logic       i_frame_start;
    logic       i_px_valid;
    logic [9:0] i_px_x;
    logic [9:0] i_px_y;
    logic       o_px_valid;
    logic [7:0] o_r;
    logic [7:0] o_g;
    logic [7:0] o_b;

    modport master (
        output i_wr_en, i_wr_addr, i_wr_data, i_cursor, i_frame_start,
        output i_px_valid, i_px_x, i_px_y,
        input  o_px_valid, o_r, o_g, o_b
    );

    modport slave (
        input  i_wr_en, i_wr_addr, i_wr_data, i_cursor, i_frame_start,
        input  i_px_valid, i_px_x, i_px_y,
        output o_px_valid, o_r, o_g, o_b
    );
endinterface

// File: rtl/board_renderer.sv
// Board renderer: keeps a working and a frame-latched display copy of a
// 4x5 block board and turns pixel requests into colours through a
// two-stage pipeline (geometry, then cell lookup / palette / outline).
module board_renderer #(
    parameter int CELL_SIZE    = 96,
    parameter int BOARD_X0     = 128,
    parameter int BOARD_Y0     = 0,
    parameter int BLINK_FRAMES = 30
) (
    input  logic            i_clk,
    input  logic            i_rst,
    board_renderer_if.slave bus
);
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [10:0] X_LO    = 11'(BOARD_X0);
    localparam logic [10:0] X_HI    = 11'(BOARD_X0 + 4 * CELL_SIZE);
    localparam logic [10:0] Y_LO    = 11'(BOARD_Y0);
    localparam logic [10:0] Y_HI    = 11'(BOARD_Y0 + 5 * CELL_SIZE);
    localparam logic [10:0] C1      = 11'(CELL_SIZE);
    localparam logic [10:0] C2      = 11'(2 * CELL_SIZE);
    localparam logic [10:0] C3      = 11'(3 * CELL_SIZE);
    localparam logic [10:0] C4      = 11'(4 * CELL_SIZE);
    localparam logic [10:0] EDGE_HI = 11'(CELL_SIZE - 2);

    // Mux-based cell read; any index past the board reads as empty.
    function automatic logic [3:0] cell_of(input logic [19:0][3:0] brd,
                                           input logic [4:0]       idx);
        logic [3:0] id;
        id = '0;
        for (int i = 0; i < 20; i++) begin
            if (idx == 5'(i)) id = brd[i];
        end
        return id;
    endfunction

    function automatic logic [23:0] palette(input logic [3:0] id);
        logic [23:0] rgb;
        case (id)
            4'd1:                   rgb = 24'hE02020;
            4'd2, 4'd3, 4'd4, 4'd5: rgb = 24'h2060E0;
            4'd6, 4'd7, 4'd8, 4'd9: rgb = 24'h20C040;
            4'd10:                  rgb = 24'hE0C020;
            default:                rgb = 24'h404040;
        endcase
        return rgb;
    endfunction

    logic [19:0][3:0]   work_board;
    logic [19:0][3:0]   disp_board;
    logic [4:0]         disp_cursor;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    // Board writes, frame-boundary snapshot and cursor blink timing.
    // The snapshot reads work_board before this cycle's write lands.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            work_board  <= '0;
            disp_board  <= '0;
            disp_cursor <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (bus.i_wr_en && (bus.i_wr_addr < 5'd20)) begin
                work_board[bus.i_wr_addr] <= bus.i_wr_data;
            end
            if (bus.i_frame_start) begin
                disp_board  <= work_board;
                disp_cursor <= bus.i_cursor;
                if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BLINK_W'(1);
                end
            end
        end
    end

    logic [10:0] px_x;
    logic [10:0] px_y;
    logic [10:0] dx;
    logic [10:0] dy;
    logic [10:0] ox_c;
    logic [10:0] oy_c;
    logic [1:0]  col_c;
    logic [2:0]  row_c;
    logic        inside_c;

    // Stage 1 geometry: compare chains against cell multiples instead of a divider.
    always_comb begin
        px_x     = {1'b0, bus.i_px_x};
        px_y     = {1'b0, bus.i_px_y};
        dx       = px_x - X_LO;
        dy       = px_y - Y_LO;
        inside_c = (px_x >= X_LO) && (px_x < X_HI) && (px_y >= Y_LO) && (px_y < Y_HI);

        if (dx < C1) begin
            col_c = 2'd0;
            ox_c  = dx;
        end else if (dx < C2) begin
            col_c = 2'd1;
            ox_c  = dx - C1;
        end else if (dx < C3) begin
            col_c = 2'd2;
            ox_c  = dx - C2;
        end else begin
            col_c = 2'd3;
            ox_c  = dx - C3;
        end

        if (dy < C1) begin
            row_c = 3'd0;
            oy_c  = dy;
        end else if (dy < C2) begin
            row_c = 3'd1;
            oy_c  = dy - C1;
        end else if (dy < C3) begin
            row_c = 3'd2;
            oy_c  = dy - C2;
        end else if (dy < C4) begin
            row_c = 3'd3;
            oy_c  = dy - C3;
        end else begin
            row_c = 3'd4;
            oy_c  = dy - C4;
        end
    end

    logic        s1_valid;
    logic        s1_inside;
    logic [1:0]  s1_col;
    logic [2:0]  s1_row;
    logic [10:0] s1_ox;
    logic [10:0] s1_oy;

    // Stage 1 register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid  <= 1'b0;
            s1_inside <= 1'b0;
            s1_col    <= '0;
            s1_row    <= '0;
            s1_ox     <= '0;
            s1_oy     <= '0;
        end else begin
            s1_valid  <= bus.i_px_valid;
            s1_inside <= inside_c;
            s1_col    <= col_c;
            s1_row    <= row_c;
            s1_ox     <= ox_c;
            s1_oy     <= oy_c;
        end
    end

    logic [4:0]  cell_idx;
    logic [3:0]  id_c;
    logic [3:0]  id_l;
    logic [3:0]  id_r;
    logic [3:0]  id_u;
    logic [3:0]  id_d;
    logic        edge_l;
    logic        edge_r;
    logic        edge_u;
    logic        edge_d;
    logic        border;
    logic [23:0] base_rgb;
    logic [23:0] pix_rgb;

    // Stage 2 colour: outlines only where the neighbour differs or is off-board.
    always_comb begin
        cell_idx = {s1_row, 2'b00} + {3'b000, s1_col};
        id_c     = cell_of(disp_board, cell_idx);
        id_l     = cell_of(disp_board, cell_idx - 5'd1);
        id_r     = cell_of(disp_board, cell_idx + 5'd1);
        id_u     = cell_of(disp_board, cell_idx - 5'd4);
        id_d     = cell_of(disp_board, cell_idx + 5'd4);

        edge_l = (s1_ox < 11'd2)    && ((s1_col == 2'd0) || (id_l != id_c));
        edge_r = (s1_ox >= EDGE_HI) && ((s1_col == 2'd3) || (id_r != id_c));
        edge_u = (s1_oy < 11'd2)    && ((s1_row == 3'd0) || (id_u != id_c));
        edge_d = (s1_oy >= EDGE_HI) && ((s1_row == 3'd4) || (id_d != id_c));
        border = edge_l || edge_r || edge_u || edge_d;

        base_rgb = palette(id_c);
        if (!s1_inside || border) begin
            pix_rgb = '0;
        end else if (blink_phase && (cell_idx == disp_cursor)) begin
            pix_rgb = ~base_rgb;
        end else begin
            pix_rgb = base_rgb;
        end
    end

    logic        out_valid;
    logic [23:0] out_rgb;

    // Stage 2 register; colour held at zero whenever no response is valid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_valid <= 1'b0;
            out_rgb   <= '0;
        end else begin
            out_valid <= s1_valid;
            out_rgb   <= s1_valid ? pix_rgb : '0;
        end
    end

    // Reset is synchronous, so the output register still holds the last pixel
    // during the reset cycle itself; masking here keeps a response from
    // escaping while reset is asserted.
    assign bus.o_px_valid = out_valid & ~i_rst;
    assign bus.o_r        = i_rst ? 8'h00 : out_rgb[23:16];
    assign bus.o_g        = i_rst ? 8'h00 : out_rgb[15:8];
    assign bus.o_b        = i_rst ? 8'h00 : out_rgb[7:0];
endmodule
